// File: rtl/memory_pkg.sv
// -----------------------------------------------------------------------------
// memory_pkg
// Shared encodings for the memory responder: access size codes, R_W polarity,
// the handshake FSM state type and a helper that turns a size code into a
// big-endian byte-lane enable mask (lane 3 = byte at the base address).
// No ports (package).
// -----------------------------------------------------------------------------
package memory_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Size code 2'b11 behaves as a word.
    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: lane_mask = 4'b1000;
            SZ_HALF: lane_mask = 4'b1100;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/memory_responder_if.sv
// -----------------------------------------------------------------------------
// memory_responder_if
// MOV/MOC handshake bundle between the CPU control unit (master) and the
// memory responder (slave).
//   MOV, R_W, size, SE, addr, data_in : request, driven by master
//   data_out, MOC                     : response, driven by slave
//   fault                             : misalignment flag, present only when
//                                       MEMORY_RESPONDER_ALIGN_FAULT_EN is set
// -----------------------------------------------------------------------------
interface memory_responder_if #(
    parameter int ADDR_W = 8
);
    logic              MOV;
    logic              R_W;
    logic [1:0]        size;
    logic              SE;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data_in;
    logic [31:0]       data_out;
    logic              MOC;
`ifdef MEMORY_RESPONDER_ALIGN_FAULT_EN
    logic              fault;

    modport master (output MOV, R_W, size, SE, addr, data_in,
                    input  data_out, MOC, fault);
    modport slave  (input  MOV, R_W, size, SE, addr, data_in,
                    output data_out, MOC, fault);
`else
    modport master (output MOV, R_W, size, SE, addr, data_in,
                    input  data_out, MOC);
    modport slave  (input  MOV, R_W, size, SE, addr, data_in,
                    output data_out, MOC);
`endif
endinterface

// File: rtl/memory_array.sv
// -----------------------------------------------------------------------------
// memory_array
// 2**ADDR_W byte array. One base address serves both the 4-lane write and the
// combinational 4-byte big-endian read; lane addresses wrap modulo the depth.
//   clk      : write clock
//   we_i     : byte-lane write enables, bit 3 = byte at addr_i
//   addr_i   : base byte address
//   wdata_i  : write data, bits [31:24] go to addr_i
//   rdata_o  : mem[addr]:mem[addr+1]:mem[addr+2]:mem[addr+3]
// Contents are not reset.
// -----------------------------------------------------------------------------
module memory_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] lane_addr [4];

    // Natural overflow of the ADDR_W-bit sum gives the modulo wrap.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = addr_i + ADDR_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[3-i]) begin
                mem_q[lane_addr[i]] <= wdata_i[31-8*i -: 8];
            end
        end
    end

    assign rdata_o = {mem_q[lane_addr[0]], mem_q[lane_addr[1]],
                      mem_q[lane_addr[2]], mem_q[lane_addr[3]]};

endmodule

// File: rtl/memory_responder.sv
// -----------------------------------------------------------------------------
// memory_responder
// Memory-side end of the MOV/MOC handshake. Captures a request, waits
// WAIT_CYCLES, then on the edge entering DONE commits a write or loads
// data_out with the (zero/sign-extended) big-endian read, and holds MOC until
// MOV drops.
//   clk : system clock, rising edge
//   clr : asynchronous active-high reset (array contents untouched)
//   bus : memory_responder_if slave modport (MOV, R_W, size, SE, addr,
//         data_in in; data_out, MOC out; fault out when enabled)
// Optional: MEMORY_RESPONDER_ALIGN_FAULT_EN turns misaligned halfword/word
// requests into no-op accesses that complete with fault=1.
//
// state | meaning
// IDLE  | waiting for MOV; captures request on the edge MOV is sampled
// WAIT  | counting down the programmed wait, inputs ignored
// DONE  | access done, MOC=1 until MOV is sampled low
// -----------------------------------------------------------------------------
module memory_responder
    import memory_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                clr,
    memory_responder_if.slave   bus
);
    localparam int              CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_rw_q, req_rw_d;
    logic [1:0]        req_size_q, req_size_d;
    logic              req_se_q, req_se_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [31:0]       req_data_q, req_data_d;
    logic [31:0]       data_out_q, data_out_d;
    logic              moc_q;

    logic              cur_rw, cur_se;
    logic [1:0]        cur_size;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_data;
    logic              enter_done, misaligned;
    logic [3:0]        mem_we;
    logic [31:0]       mem_wdata, mem_rdata, rd_ext;

    // With WAIT_CYCLES=0 the access completes on the capture edge itself, so
    // in IDLE the live inputs stand in for the not-yet-latched request.
    always_comb begin
        if (state_q == IDLE) begin
            cur_rw   = bus.R_W;
            cur_size = bus.size;
            cur_se   = bus.SE;
            cur_addr = bus.addr;
            cur_data = bus.data_in;
        end else begin
            cur_rw   = req_rw_q;
            cur_size = req_size_q;
            cur_se   = req_se_q;
            cur_addr = req_addr_q;
            cur_data = req_data_q;
        end
    end

`ifdef MEMORY_RESPONDER_ALIGN_FAULT_EN
    assign misaligned = ((cur_size == SZ_HALF) && cur_addr[0]) ||
                        (cur_size[1] && (cur_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Right-justified write data is moved up so its first byte sits in lane 3.
    always_comb begin
        case (cur_size)
            SZ_BYTE: mem_wdata = {cur_data[7:0], 24'h0};
            SZ_HALF: mem_wdata = {cur_data[15:0], 16'h0};
            default: mem_wdata = cur_data;
        endcase
    end

    always_comb begin
        case (cur_size)
            SZ_BYTE: rd_ext = {{24{cur_se & mem_rdata[31]}}, mem_rdata[31:24]};
            SZ_HALF: rd_ext = {{16{cur_se & mem_rdata[31]}}, mem_rdata[31:16]};
            default: rd_ext = mem_rdata;
        endcase
    end

    assign mem_we = (enter_done && (cur_rw == RW_WRITE) && !misaligned)
                    ? lane_mask(cur_size) : 4'b0000;

    memory_array #(.ADDR_W(ADDR_W)) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (cur_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_rw_d   = req_rw_q;
        req_size_d = req_size_q;
        req_se_d   = req_se_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        data_out_d = data_out_q;
        enter_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.MOV) begin
                    req_rw_d   = bus.R_W;
                    req_size_d = bus.size;
                    req_se_d   = bus.SE;
                    req_addr_d = bus.addr;
                    req_data_d = bus.data_in;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (!bus.MOV) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_done && (cur_rw == RW_READ) && !misaligned) begin
            data_out_d = rd_ext;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_rw_q   <= 1'b0;
            req_size_q <= 2'b00;
            req_se_q   <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
            data_out_q <= '0;
            moc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_rw_q   <= req_rw_d;
            req_size_q <= req_size_d;
            req_se_q   <= req_se_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            data_out_q <= data_out_d;
            moc_q      <= (state_d == DONE);
        end
    end

    assign bus.MOC      = moc_q;
    assign bus.data_out = data_out_q;

`ifdef MEMORY_RESPONDER_ALIGN_FAULT_EN
    logic fault_q;

    // Set with the completing edge, cleared when DONE is left.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            fault_q <= 1'b0;
        end else if (enter_done) begin
            fault_q <= misaligned;
        end else if (state_d != DONE) begin
            fault_q <= 1'b0;
        end
    end

    assign bus.fault = fault_q;
`endif

endmodule

// File: tb/tb_memory_responder.sv
module tb_memory_responder;
    import memory_pkg::*;

    localparam int ADDR_W      = 8;
    localparam int WAIT_CYCLES = 2;
    localparam int DEPTH       = 2 ** ADDR_W;
`ifdef MEMORY_RESPONDER_ALIGN_FAULT_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr;

    memory_responder_if #(.ADDR_W(ADDR_W)) bus ();

    memory_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  ref_mem [DEPTH];
    logic [31:0] ref_dout;
    logic [31:0] rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        if (sz == SZ_BYTE) return 1;
        if (sz == SZ_HALF) return 2;
        return 4;
    endfunction

    function automatic bit misaligned(input logic [1:0] sz, input logic [7:0] a);
        int n;
        n = nbytes(sz);
        return (n > 1) && ((int'(a) % n) != 0);
    endfunction

    // Big-endian value of n bytes from the wrapped byte array, then extended.
    function automatic logic [31:0] model_read(input logic [1:0] sz, input bit se, input logic [7:0] a);
        longint v;
        int     n;
        v = 0;
        n = nbytes(sz);
        for (int k = 0; k < n; k++) v = v * 256 + longint'(ref_mem[(int'(a) + k) % DEPTH]);
        if (se && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_write(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] d);
        int n;
        n = nbytes(sz);
        for (int k = 0; k < n; k++) ref_mem[(int'(a) + k) % DEPTH] = 8'(d >> (8 * (n - 1 - k)));
    endtask

    task automatic access(input bit rw, input logic [1:0] sz, input bit se, input logic [7:0] a,
                          input logic [31:0] wd, input int hold, input bit drop_early,
                          output logic [31:0] dout);
        int lat;
        bit mis;
        mis = ALIGN_EN && misaligned(sz, a);
        @(negedge clk);
        bus.MOV = 1'b1; bus.R_W = rw; bus.size = sz; bus.SE = se; bus.addr = a; bus.data_in = wd;
        @(posedge clk); #1;
        lat = 1;
        // Request is latched now; scramble inputs to show they are ignored.
        bus.addr = 8'($urandom); bus.data_in = $urandom; bus.size = 2'($urandom);
        bus.SE = 1'($urandom); bus.R_W = 1'($urandom);
        if (drop_early) bus.MOV = 1'b0;
        while (bus.MOC !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(WAIT_CYCLES + 1));
        if (!mis) begin
            if (rw) ref_dout = model_read(sz, se, a);
            else model_write(sz, a, wd);
        end
        chk("data_out", bus.data_out, ref_dout);
`ifdef MEMORY_RESPONDER_ALIGN_FAULT_EN
        chk("fault_done", 32'(bus.fault), 32'(mis));
`endif
        dout = bus.data_out;
        if (drop_early) begin
            @(posedge clk); #1;
            chk("moc_pulse", 32'(bus.MOC), 32'd0);
        end else begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("moc_hold", 32'(bus.MOC), 32'd1);
            end
            @(negedge clk);
            bus.MOV = 1'b0;
            @(posedge clk); #1;
            chk("moc_fall", 32'(bus.MOC), 32'd0);
        end
`ifdef MEMORY_RESPONDER_ALIGN_FAULT_EN
        chk("fault_idle", 32'(bus.fault), 32'd0);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr = 1'b1;
        bus.MOV = 1'b0; bus.R_W = 1'b0; bus.size = SZ_WORD; bus.SE = 1'b0;
        bus.addr = '0; bus.data_in = '0;
        ref_dout = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        #12;
        chk("rst_moc", 32'(bus.MOC), 32'd0);
        chk("rst_dout", bus.data_out, 32'd0);
        @(negedge clk);
        clr = 1'b0;

        // Give every byte a known value.
        for (int i = 0; i < DEPTH / 4; i++)
            access(RW_WRITE, SZ_WORD, 1'b0, 8'(i * 4), $urandom, 0, 1'b0, rd);

        access(RW_WRITE, SZ_WORD, 1'b0, 8'h10, 32'hDEADBEEF, 0, 1'b0, rd);
        access(RW_READ,  SZ_WORD, 1'b0, 8'h10, 32'h0, 0, 1'b0, rd);
        chk("word_rd", rd, 32'hDEADBEEF);
        access(RW_READ,  SZ_BYTE, 1'b1, 8'h13, 32'h0, 0, 1'b0, rd);
        chk("byte_se", rd, 32'hFFFFFFEF);
        access(RW_READ,  SZ_BYTE, 1'b0, 8'h13, 32'h0, 0, 1'b0, rd);
        chk("byte_ze", rd, 32'h000000EF);
        access(RW_READ,  SZ_HALF, 1'b1, 8'h10, 32'h0, 0, 1'b0, rd);
        chk("half_se", rd, 32'hFFFFDEAD);
        access(RW_WRITE, SZ_BYTE, 1'b0, 8'h11, 32'h12345678, 0, 1'b0, rd);
        chk("dout_held", rd, 32'hFFFFDEAD);
        access(RW_READ,  SZ_WORD, 1'b0, 8'h10, 32'h0, 5, 1'b0, rd);
        chk("byte_iso", rd, 32'hDE78BEEF);

        // Early MOV drop on a write, then confirm it committed.
        access(RW_WRITE, SZ_WORD, 1'b0, 8'h30, 32'hCAFEF00D, 0, 1'b1, rd);
        access(RW_READ,  SZ_WORD, 1'b0, 8'h30, 32'h0, 0, 1'b0, rd);
        chk("early_commit", rd, 32'hCAFEF00D);

`ifdef MEMORY_RESPONDER_ALIGN_FAULT_EN
        access(RW_WRITE, SZ_WORD, 1'b0, 8'h20, 32'h11223344, 0, 1'b0, rd);
        access(RW_WRITE, SZ_WORD, 1'b0, 8'h22, 32'hAABBCCDD, 0, 1'b0, rd);
        access(RW_READ,  SZ_WORD, 1'b0, 8'h20, 32'h0, 0, 1'b0, rd);
        chk("fault_nowrite", rd, 32'h11223344);
        access(RW_READ,  SZ_HALF, 1'b0, 8'h21, 32'h0, 0, 1'b0, rd);
        chk("fault_dout_held", rd, 32'h11223344);
`else
        access(RW_WRITE, SZ_WORD, 1'b0, 8'hFE, 32'h01020304, 0, 1'b0, rd);
        access(RW_READ,  SZ_BYTE, 1'b0, 8'hFE, 32'h0, 0, 1'b0, rd);
        chk("wrap_fe", rd, 32'h01);
        access(RW_READ,  SZ_BYTE, 1'b0, 8'hFF, 32'h0, 0, 1'b0, rd);
        chk("wrap_ff", rd, 32'h02);
        access(RW_READ,  SZ_BYTE, 1'b0, 8'h00, 32'h0, 0, 1'b0, rd);
        chk("wrap_00", rd, 32'h03);
        access(RW_READ,  SZ_BYTE, 1'b0, 8'h01, 32'h0, 0, 1'b0, rd);
        chk("wrap_01", rd, 32'h04);
        access(RW_READ,  SZ_WORD, 1'b0, 8'hFF, 32'h0, 0, 1'b0, rd);
        chk("wrap_rd", rd, 32'h02030400 | 32'(ref_mem[2]));
`endif

        // Abort a write to 0x40 mid-WAIT.
        access(RW_READ, SZ_WORD, 1'b0, 8'h10, 32'h0, 0, 1'b0, rd);
        @(negedge clk);
        bus.MOV = 1'b1; bus.R_W = RW_WRITE; bus.size = SZ_WORD; bus.SE = 1'b0;
        bus.addr = 8'h40; bus.data_in = ~{ref_mem[8'h40], ref_mem[8'h41], ref_mem[8'h42], ref_mem[8'h43]};
        @(posedge clk); #1;
        bus.MOV = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("clr_moc", 32'(bus.MOC), 32'd0);
        chk("clr_dout", bus.data_out, 32'd0);
        ref_dout = '0;
        @(negedge clk);
        clr = 1'b0;
        access(RW_READ, SZ_WORD, 1'b0, 8'h40, 32'h0, 0, 1'b0, rd);

        // Randomized traffic against the byte-array model.
        for (int i = 0; i < 150; i++) begin
            access(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), $urandom,
                   int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0), rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
